// File: rtl/barrido_tabla_verdad_if.sv
// Handshake and result bundle between the truth-table scanner (master)
// and the function under test plus its result consumer (slave).
interface barrido_tabla_verdad_if #(
  parameter int N_IN = 5
);
  logic                 start;
  logic                 F_in;
  logic [N_IN-1:0]      stim;
  logic                 busy;
  logic                 done;
  logic                 valid;
  logic [2**N_IN-1:0]   tabla;
  logic [N_IN:0]        unos;
  logic                 hay_minterm;
  logic [N_IN-1:0]      primer_minterm;

  modport master (
    input  start, F_in,
    output stim, busy, done, valid, tabla, unos, hay_minterm, primer_minterm
  );

  modport slave (
    output start, F_in,
    input  stim, busy, done, valid, tabla, unos, hay_minterm, primer_minterm
  );
endinterface

// File: rtl/barrido_tabla_verdad.sv
// Sequential truth-table scanner: steps every input combination through the
// function under test, lets it settle, samples F and builds table/statistics.
module barrido_tabla_verdad #(
  parameter int N_IN          = 5,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  barrido_tabla_verdad_if.master bus
);
  localparam int              DEPTH       = 2**N_IN;
  localparam logic [N_IN-1:0] LAST        = N_IN'(DEPTH-1);
  localparam logic [3:0]      SETTLE_LOAD = 4'(SETTLE_CYCLES-1);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, FIN} state_t;

  state_t            state;
  logic [3:0]        settle_cnt;
  logic [N_IN-1:0]   stim;
  logic              busy;
  logic              done;
  logic              valid;
  logic [DEPTH-1:0]  tabla;
  logic [N_IN:0]     unos;
  logic              hay_minterm;
  logic [N_IN-1:0]   primer_minterm;

  // stim doubles as the scan index: it only moves when a new DRIVE begins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      settle_cnt     <= '0;
      stim           <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      valid          <= 1'b0;
      tabla          <= '0;
      unos           <= '0;
      hay_minterm    <= 1'b0;
      primer_minterm <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            tabla          <= '0;
            unos           <= '0;
            hay_minterm    <= 1'b0;
            primer_minterm <= '0;
            valid          <= 1'b0;
            stim           <= '0;
            settle_cnt     <= SETTLE_LOAD;
            busy           <= 1'b1;
            state          <= DRIVE;
          end
        end
        DRIVE: begin
          if (settle_cnt == 4'd0) state <= SAMPLE;
          else                    settle_cnt <= settle_cnt - 4'd1;
        end
        SAMPLE: begin
          tabla[stim] <= bus.F_in;
          unos        <= unos + {{N_IN{1'b0}}, bus.F_in};
          if (bus.F_in) begin
            hay_minterm <= 1'b1;
            if (!hay_minterm) primer_minterm <= stim;
          end
          // terminal check before increment so the index never wraps
          if (stim == LAST) begin
            done  <= 1'b1;
            state <= FIN;
          end else begin
            stim       <= stim + 1'b1;
            settle_cnt <= SETTLE_LOAD;
            state      <= DRIVE;
          end
        end
        FIN: begin
          valid <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.stim           = stim;
  assign bus.busy           = busy;
  assign bus.done           = done;
  assign bus.valid          = valid;
  assign bus.tabla          = tabla;
  assign bus.unos           = unos;
  assign bus.hay_minterm    = hay_minterm;
  assign bus.primer_minterm = primer_minterm;
endmodule
